// File: rtl/bounce_pkg.sv
// Shared types and defaults for the bouncing-square motion scheduler.
package bounce_pkg;

  // Default active area of the display.
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Coordinate width carried by axis_t; the scheduler's CORDW defaults to it.
  localparam int COORD_W = 10;

  // Scheduler sequence: x then y of each object, then one publish cycle.
  typedef enum logic [1:0] {
    IDLE,
    STEP_X,
    STEP_Y,
    PUBLISH
  } sched_state_t;

  // Operands of one axis of one object, as presented to the shared step unit.
  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic [COORD_W-1:0] size;
    logic [COORD_W-1:0] speed;
    logic               dir;
  } axis_t;

endpackage

// File: rtl/bounce_step.sv
// Single-axis bounce step: computes next position and direction of one object
// along one axis. Purely combinational; shared across all objects and axes.
module bounce_step #(
  parameter int CORDW = 10
) (
  input  logic [CORDW-1:0] pos,
  input  logic             dir,
  input  logic [CORDW-1:0] size,
  input  logic [CORDW-1:0] speed,
  input  logic [CORDW+1:0] limit,
  output logic [CORDW-1:0] pos_next,
  output logic             dir_next
);

  localparam int W = CORDW + 2;

  logic [W-1:0]     p_w;
  logic [W-1:0]     s_w;
  logic [W-1:0]     extent;
  logic [CORDW-1:0] pos_up;
  logic [CORDW-1:0] pos_dn;

  // Widened operands so size+speed and the edge compare cannot wrap.
  assign p_w    = W'(pos);
  assign s_w    = W'(speed);
  assign extent = W'(size) + s_w;
  assign pos_up = pos + speed;
  assign pos_dn = pos - speed;

  // Edge handling: oversize objects park at 0, otherwise reflect at the edges.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    pos_next = pos;
    dir_next = dir;
    if (extent >= limit) begin
      pos_next = '0;
    end else if (p_w >= limit - extent) begin
      dir_next = 1'b1;
      pos_next = pos_dn;
    end else if (p_w < s_w) begin
      dir_next = 1'b0;
      pos_next = pos_up;
    end else begin
      pos_next = dir ? pos_dn : pos_up;
    end
  end

endmodule

// File: rtl/bounce_motion_sched.sv
// Time-multiplexed motion scheduler for N_OBJ bouncing squares. Once per frame it
// walks every object's x then y through one shared step unit, then publishes the
// whole working set at once so the draw logic never sees a half-updated frame.
module bounce_motion_sched
  import bounce_pkg::*;
#(
  parameter int N_OBJ = 3,
  parameter int CORDW = COORD_W,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  localparam int IDXW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk_pix,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [IDXW-1:0]        cfg_idx,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  input  logic [CORDW-1:0]       cfg_size,
  input  logic [CORDW-1:0]       cfg_speed,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [N_OBJ*CORDW-1:0] obj_x,
  output logic [N_OBJ*CORDW-1:0] obj_y,
  output logic [N_OBJ*CORDW-1:0] obj_size
);

  localparam int LW = CORDW + 2;

  sched_state_t     state, state_next;
  logic [IDXW-1:0]  idx, idx_next;

  logic [CORDW-1:0] x_pos   [N_OBJ];
  logic [CORDW-1:0] y_pos   [N_OBJ];
  logic [CORDW-1:0] obj_sz  [N_OBJ];
  logic [CORDW-1:0] obj_spd [N_OBJ];
  logic [N_OBJ-1:0] dir_x;
  logic [N_OBJ-1:0] dir_y;

  logic [CORDW-1:0] pub_x  [N_OBJ];
  logic [CORDW-1:0] pub_y  [N_OBJ];
  logic [CORDW-1:0] pub_sz [N_OBJ];

  axis_t            step_in;
  logic             step_is_y;
  logic [LW-1:0]    step_limit;
  logic [CORDW-1:0] step_pos;
  logic             step_dir;
  logic             cfg_hit;

  assign busy      = (state != IDLE);
  assign cfg_ready = !busy;
  // Writes only land while idle, so they never race the step unit.
  assign cfg_hit   = cfg_we && cfg_ready && (int'(cfg_idx) < N_OBJ);

  // Sequencer state and object index register.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state walk: x then y of each object, then a single publish cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = STEP_X;
          idx_next   = '0;
        end
      end
      STEP_X:  state_next = STEP_Y;
      STEP_Y: begin
        if (idx == IDXW'(N_OBJ - 1)) begin
          state_next = PUBLISH;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = STEP_X;
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand mux feeding the shared step unit for the current object and axis.
  always_comb begin
    step_is_y     = (state == STEP_Y);
    step_in.pos   = step_is_y ? y_pos[idx] : x_pos[idx];
    step_in.size  = obj_sz[idx];
    step_in.speed = obj_spd[idx];
    step_in.dir   = step_is_y ? dir_y[idx] : dir_x[idx];
    step_limit    = step_is_y ? LW'(V_RES) : LW'(H_RES);
  end

  bounce_step #(.CORDW(CORDW)) u_step (
    .pos      (step_in.pos),
    .dir      (step_in.dir),
    .size     (step_in.size),
    .speed    (step_in.speed),
    .limit    (step_limit),
    .pos_next (step_pos),
    .dir_next (step_dir)
  );

  // Working set: loaded by config writes, advanced one axis per step cycle.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are a few flops rather than a RAM, so resetting them is cheap and intended.
      for (int i = 0; i < N_OBJ; i++) begin
        x_pos[i]   <= '0;
        y_pos[i]   <= '0;
        obj_sz[i]  <= '0;
        obj_spd[i] <= '0;
      end
      dir_x <= '0;
      dir_y <= '0;
    end else if (cfg_hit) begin
      x_pos[cfg_idx]   <= cfg_x;
      y_pos[cfg_idx]   <= cfg_y;
      obj_sz[cfg_idx]  <= cfg_size;
      obj_spd[cfg_idx] <= cfg_speed;
      dir_x[cfg_idx]   <= 1'b0;
      dir_y[cfg_idx]   <= 1'b0;
    end else if (state == STEP_X) begin
      x_pos[idx] <= step_pos;
      dir_x[idx] <= step_dir;
    end else if (state == STEP_Y) begin
      y_pos[idx] <= step_pos;
      dir_y[idx] <= step_dir;
    end
  end

  // Published copy seen by the draw logic; changes only on publish or a config write.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        pub_x[i]  <= '0;
        pub_y[i]  <= '0;
        pub_sz[i] <= '0;
      end
    end else if (cfg_hit) begin
      pub_x[cfg_idx]  <= cfg_x;
      pub_y[cfg_idx]  <= cfg_y;
      pub_sz[cfg_idx] <= cfg_size;
    end else if (state == PUBLISH) begin
      for (int i = 0; i < N_OBJ; i++) begin
        pub_x[i]  <= x_pos[i];
        pub_y[i]  <= y_pos[i];
        pub_sz[i] <= obj_sz[i];
      end
    end
  end

  // Status: done marks the cycle the publish lands; overrun latches a missed frame.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= (state == PUBLISH);
      overrun <= overrun | (frame_start && busy);
    end
  end

  // Flatten the published arrays onto the packed output buses.
  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign obj_x[g*CORDW +: CORDW]    = pub_x[g];
    assign obj_y[g*CORDW +: CORDW]    = pub_y[g];
    assign obj_size[g*CORDW +: CORDW] = pub_sz[g];
  end

endmodule

// File: tb/tb_bounce_motion_sched.sv
// Directed bench for bounce_motion_sched: reset state, latency, edge bounces,
// oversize objects, overrun and busy-time config, and reset mid-sequence.
module tb_bounce_motion_sched;

  localparam int N_OBJ = 3;
  localparam int CORDW = 10;

  logic                   clk_pix = 1'b0;
  logic                   rst_n;
  logic                   frame_start;
  logic                   cfg_we;
  logic                   cfg_ready;
  logic [1:0]             cfg_idx;
  logic [CORDW-1:0]       cfg_x, cfg_y, cfg_size, cfg_speed;
  logic                   busy, done, overrun;
  logic [N_OBJ*CORDW-1:0] obj_x, obj_y, obj_size;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_pix = ~clk_pix;

  bounce_motion_sched #(
    .N_OBJ (N_OBJ),
    .CORDW (CORDW),
    .H_RES (640),
    .V_RES (480)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_ready   (cfg_ready),
    .cfg_idx     (cfg_idx),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_size    (cfg_size),
    .cfg_speed   (cfg_speed),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_size    (obj_size)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [CORDW-1:0] px(input int i);
    return obj_x[i*CORDW +: CORDW];
  endfunction

  function automatic logic [CORDW-1:0] py(input int i);
    return obj_y[i*CORDW +: CORDW];
  endfunction

  function automatic logic [CORDW-1:0] psz(input int i);
    return obj_size[i*CORDW +: CORDW];
  endfunction

  task automatic cfg_write(input int idx, input int x, input int y, input int sz, input int spd);
    @(negedge clk_pix);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_x     = CORDW'(x);
    cfg_y     = CORDW'(y);
    cfg_size  = CORDW'(sz);
    cfg_speed = CORDW'(spd);
    @(negedge clk_pix);
    cfg_we    = 1'b0;
  endtask

  // Pulse frame_start and return cycles until done; 50 means it never came.
  task automatic run_frame(output int lat);
    @(negedge clk_pix);
    frame_start = 1'b1;
    @(negedge clk_pix);
    frame_start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk_pix);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;

    rst_n = 1'b0; frame_start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_x = '0; cfg_y = '0; cfg_size = '0; cfg_speed = '0;
    repeat (2) @(negedge clk_pix);

    // Reset state
    check("rst_obj_x", obj_x, 0);
    check("rst_obj_y", obj_y, 0);
    check("rst_obj_size", obj_size, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk_pix);

    // 1: basic move and latency
    cfg_write(0, 100, 50, 100, 2);
    check("t1_cfg_pub_x0", px(0), 100);
    check("t1_cfg_pub_size0", psz(0), 100);
    run_frame(lat);
    check("t1_latency", lat, 7);
    check("t1_x0", px(0), 102);
    check("t1_y0", py(0), 52);
    check("t1_x1_idle_obj", px(1), 0);
    @(negedge clk_pix);
    check("t1_done_one_cycle", done, 0);
    check("t1_busy_after", busy, 0);

    // 2: far edge reflection
    cfg_write(0, 538, 50, 100, 2);
    run_frame(lat);
    check("t2_latency", lat, 7);
    check("t2_x0_f1", px(0), 536);
    check("t2_y0_f1", py(0), 52);
    run_frame(lat);
    check("t2_x0_f2", px(0), 534);
    check("t2_y0_f2", py(0), 54);

    // 3: near edge reflection (far edge sits at x=2 for this size)
    cfg_write(1, 3, 10, 636, 2);
    run_frame(lat);
    check("t3_x1_f1", px(1), 1);
    check("t3_y1_oversize", py(1), 0);
    check("t3_size1", psz(1), 636);
    run_frame(lat);
    check("t3_x1_f2", px(1), 3);
    run_frame(lat);
    check("t3_x1_f3", px(1), 1);

    // 4: oversize object parks at 0 every frame
    cfg_write(2, 100, 100, 600, 50);
    check("t4_cfg_pub_x2", px(2), 100);
    run_frame(lat);
    check("t4_x2_f1", px(2), 0);
    check("t4_y2_f1", py(2), 0);
    run_frame(lat);
    check("t4_x2_f2", px(2), 0);
    check("t4_size2", psz(2), 600);

    // 5: frame_start and config while busy
    cfg_write(0, 200, 200, 10, 5);
    check("t5_overrun_before", overrun, 0);
    dones = 0;
    @(negedge clk_pix);
    frame_start = 1'b1;
    @(negedge clk_pix);
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        check("t5_cfg_ready_busy", cfg_ready, 0);
        frame_start = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd0;
        cfg_x = 10'd7; cfg_y = 10'd7; cfg_size = 10'd7; cfg_speed = 10'd7;
      end else begin
        frame_start = 1'b0;
        cfg_we = 1'b0;
      end
      if (busy) begin
        check("t5_stable_x0", px(0), 200);
        check("t5_stable_y0", py(0), 200);
        check("t5_stable_size0", psz(0), 10);
      end
      if (done) dones++;
      @(negedge clk_pix);
    end
    check("t5_done_count", dones, 1);
    check("t5_overrun", overrun, 1);
    check("t5_x0", px(0), 205);
    check("t5_y0", py(0), 205);
    check("t5_size0_dropped_write", psz(0), 10);
    check("t5_busy_end", busy, 0);

    // 6: reset in the middle of STEP_Y
    @(negedge clk_pix);
    frame_start = 1'b1;
    @(negedge clk_pix);
    frame_start = 1'b0;
    @(negedge clk_pix);
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_obj_x", obj_x, 0);
    check("t6_obj_y", obj_y, 0);
    check("t6_obj_size", obj_size, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_overrun", overrun, 0);
    check("t6_cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk_pix);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pix);
      if (done) dones++;
    end
    check("t6_no_done", dones, 0);
    check("t6_busy_after", busy, 0);
    check("t6_x_after", obj_x, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
